// File: rtl/multi_rate_timer.sv
// Multi-rate game timer: counts base ticks up to / down from a programmable end value,
// with the tick rate scaled 1x..4x by a fractional accumulator.
module multi_rate_timer #(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned TICK_HZ     = 1000,
    parameter int unsigned WIDTH       = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic [1:0]       difficulty,
    input  logic [WIDTH-1:0] end_value,
    input  logic             count_down,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] timer_value,
    output logic             tick,
    output logic             done_pulse,
    output logic             end_reached,
    output logic             running
);

    localparam int unsigned DIV   = CLK_FREQ_HZ / TICK_HZ;
    localparam int unsigned ACC_W = $clog2(DIV + 4);
    localparam logic [ACC_W-1:0] DIV_C = ACC_W'(DIV);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_value;
    logic [ACC_W-1:0]   r_acc;
    logic               r_down;
    logic               r_reload;
    logic               r_tick;
    logic               r_done_pulse;
    logic               r_end_reached;
    logic               r_running;

    logic [ACC_W-1:0]   w_step;
    logic [ACC_W-1:0]   w_sum;
    logic               w_hit;
    logic [WIDTH-1:0]   w_next_val;
    logic               w_terminal;
    logic [WIDTH-1:0]   w_load;
    logic [WIDTH-1:0]   w_reload_val;

    always_comb begin
        w_step       = ACC_W'(difficulty) + ACC_W'(1);
        w_sum        = r_acc + w_step;
        w_hit        = (w_sum >= DIV_C);
        w_next_val   = r_down ? (r_value - 1'b1) : (r_value + 1'b1);
        // >= in up mode so a mid-run lowering of end_value still terminates
        w_terminal   = r_down ? (w_next_val == '0) : (w_next_val >= end_value);
        w_load       = count_down ? end_value : '0;
        w_reload_val = r_down ? end_value : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_value       <= '0;
            r_acc         <= '0;
            r_down        <= 1'b0;
            r_reload      <= 1'b0;
            r_tick        <= 1'b0;
            r_done_pulse  <= 1'b0;
            r_end_reached <= 1'b0;
            r_running     <= 1'b0;
        end else begin
            r_tick       <= 1'b0;
            r_done_pulse <= 1'b0;
            if (start) begin
                r_value  <= w_load;
                r_acc    <= '0;
                r_down   <= count_down;
                r_reload <= auto_reload;
                // load value equals target only when end_value is zero, in either direction
                if (end_value == '0) begin
                    r_state       <= S_DONE;
                    r_done_pulse  <= 1'b1;
                    r_end_reached <= 1'b1;
                    r_running     <= 1'b0;
                end else begin
                    r_state       <= S_RUN;
                    r_end_reached <= 1'b0;
                    r_running     <= 1'b1;
                end
            end else if (r_state == S_RUN && enable) begin
                if (w_hit) begin
                    r_acc  <= w_sum - DIV_C;
                    r_tick <= 1'b1;
                    if (w_terminal) begin
                        r_done_pulse <= 1'b1;
                        if (r_reload) begin
                            r_value <= w_reload_val;
                        end else begin
                            r_value       <= w_next_val;
                            r_state       <= S_DONE;
                            r_end_reached <= 1'b1;
                            r_running     <= 1'b0;
                        end
                    end else begin
                        r_value <= w_next_val;
                    end
                end else begin
                    r_acc <= w_sum;
                end
            end
        end
    end

    assign timer_value = r_value;
    assign tick        = r_tick;
    assign done_pulse  = r_done_pulse;
    assign end_reached = r_end_reached;
    assign running     = r_running;

endmodule
